ref_luma_window_fetch: RTL and testbench

- Reads a reference-picture luma window for one 4x4 inter-predicted block out of the ping-pong external frame store.
- Drives the ref-frame read port (`ref_frame_RAM_rd`, `ref_frame_RAM_rd_addr`, `ref_frame_RAM_dout`) that the external RAM controller routes to whichever bank currently holds the reference frame.
- Fetches a 9-row x 3-word window around the motion-compensated block position, which covers the 6-tap interpolation support.
- Clamps out-of-picture rows and columns to the picture edge and streams the padded words to the inter-prediction interpolator.

---
 rtl/ref_luma_window_fetch.sv | 181 ++++++++++++++++++
 tb/tb_ref_luma_window_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ref_luma_window_fetch.sv
// Reference luma window fetch for one 4x4 inter-predicted block.
// Reads a 9-row x 3-word window around (x0-2, y0-2) from the reference frame
// store. Rows and word columns that fall outside the picture are clamped to
// the edge, and words are byte-replicated at the left/right picture borders.
// Padded words stream out one per cycle with their row/column tags.
module ref_luma_window_fetch #(
  parameter int LUMA_W_WORDS = 44,
  parameter int LUMA_H       = 144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  output logic        busy,
  output logic        done,
  output logic        ref_frame_RAM_rd,
  output logic [13:0] ref_frame_RAM_rd_addr,
  input  logic [31:0] ref_frame_RAM_dout,
  output logic        win_valid,
  output logic [31:0] win_data,
  output logic [3:0]  win_row,
  output logic [1:0]  win_col,
  output logic [1:0]  win_xoff
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;
  typedef enum logic [1:0] {PAD_NONE, PAD_L, PAD_R} pad_t;

  localparam logic signed [10:0] ROW_MAX_S = 11'(LUMA_H - 1);
  localparam logic signed [10:0] COL_MAX_S = 11'(LUMA_W_WORDS - 1);
  localparam logic [13:0]        ROW_MAX_U = 14'(LUMA_H - 1);
  localparam logic [13:0]        COL_MAX_U = 14'(LUMA_W_WORDS - 1);
  localparam logic [13:0]        PITCH     = 14'(LUMA_W_WORDS);

  state_t      state_q, state_d;
  logic [3:0]  rc_q, rc_d;
  logic [1:0]  cc_q, cc_d;
  logic [9:0]  x0_q, x0_d;
  logic [9:0]  y0_q, y0_d;
  logic [1:0]  xoff_q, xoff_d;

  // Read-side pipeline tags travelling one cycle behind each read.
  logic        valid_q;
  logic [3:0]  row_q;
  logic [1:0]  col_q;
  pad_t        pad_q;

  // Address generation signals for the current (rc, cc).
  logic signed [10:0] ry;
  logic signed [10:0] xm;
  logic signed [10:0] wx;
  logic [13:0]        ry_c;
  logic [13:0]        wx_c;
  logic [13:0]        addr_cur;
  pad_t               pad_cur;

  // State, counters and latched block position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rc_q    <= '0;
      cc_q    <= '0;
      x0_q    <= '0;
      y0_q    <= '0;
      xoff_q  <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      cc_q    <= cc_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      xoff_q  <= xoff_d;
    end
  end

  // Next-state logic: accept start only when idle, walk the window row-major.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    cc_d    = cc_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    xoff_d  = xoff_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          rc_d    = '0;
          cc_d    = '0;
          x0_d    = x0;
          y0_d    = y0;
          // Low two bits of (x0 - 2): byte of the first needed pixel.
          xoff_d  = x0[1:0] - 2'd2;
        end
      end
      S_FETCH: begin
        if (cc_q == 2'd2) begin
          cc_d = '0;
          if (rc_q == 4'd8) begin
            rc_d    = '0;
            state_d = S_DRAIN;
          end else begin
            rc_d = rc_q + 4'd1;
          end
        end else begin
          cc_d = cc_q + 2'd1;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Clamp the window position into the picture and form the word address.
  always_comb begin
    ry      = $signed({y0_q[9], y0_q}) - 11'sd2 + $signed({7'b0, rc_q});
    xm      = $signed({x0_q[9], x0_q}) - 11'sd2;
    wx      = (xm >>> 2) + $signed({9'b0, cc_q});
    ry_c    = {3'b0, ry};
    wx_c    = {3'b0, wx};
    pad_cur = PAD_NONE;
    if (ry < 11'sd0) begin
      ry_c = '0;
    end else if (ry > ROW_MAX_S) begin
      ry_c = ROW_MAX_U;
    end
    if (wx < 11'sd0) begin
      wx_c    = '0;
      pad_cur = PAD_L;
    end else if (wx > COL_MAX_S) begin
      wx_c    = COL_MAX_U;
      pad_cur = PAD_R;
    end
    addr_cur = ry_c * PITCH + wx_c;
  end

  // Tag each read with its window position and padding so the returning
  // data can be formatted one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      pad_q   <= PAD_NONE;
    end else begin
      valid_q <= (state_q == S_FETCH);
      if (state_q == S_FETCH) begin
        row_q <= rc_q;
        col_q <= cc_q;
        pad_q <= pad_cur;
      end
    end
  end

  // Edge padding replicates the outermost pixel of the clamped word.
  always_comb begin
    win_data = '0;
    if (valid_q) begin
      case (pad_q)
        PAD_L:   win_data = {4{ref_frame_RAM_dout[7:0]}};
        PAD_R:   win_data = {4{ref_frame_RAM_dout[31:24]}};
        default: win_data = ref_frame_RAM_dout;
      endcase
    end
  end

  assign ref_frame_RAM_rd      = (state_q == S_FETCH);
  assign ref_frame_RAM_rd_addr = ref_frame_RAM_rd ? addr_cur : 14'd0;
  assign busy                  = (state_q != S_IDLE);
  assign done                  = (state_q == S_DRAIN);
  assign win_valid             = valid_q;
  assign win_row               = row_q;
  assign win_col               = col_q;
  assign win_xoff              = xoff_q;

endmodule

// File: tb/tb_ref_luma_window_fetch.sv
// Self-checking bench for ref_luma_window_fetch: directed corner cases,
// overlapping start requests, mid-transaction reset and random positions,
// all compared against a window model built from plain integer arithmetic.
module tb_ref_luma_window_fetch;

  localparam int W = 44;
  localparam int H = 144;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  x0 = '0;
  logic [9:0]  y0 = '0;
  logic        busy, done, rd;
  logic [13:0] addr;
  logic [31:0] dout;
  logic        win_valid;
  logic [31:0] win_data;
  logic [3:0]  win_row;
  logic [1:0]  win_col;
  logic [1:0]  win_xoff;

  int unsigned mem [0:W*H-1];
  int checks = 0;
  int errors = 0;

  ref_luma_window_fetch #(.LUMA_W_WORDS(W), .LUMA_H(H)) dut (
    .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0),
    .busy(busy), .done(done),
    .ref_frame_RAM_rd(rd), .ref_frame_RAM_rd_addr(addr),
    .ref_frame_RAM_dout(dout),
    .win_valid(win_valid), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .win_xoff(win_xoff)
  );

  always #5 clk = ~clk;

  // Frame store: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd) dout <= mem[int'(addr)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Word column of window column 0: floor((x-2)/4).
  function automatic int base_col(input int x);
    int xm;
    xm = x - 2;
    return (xm >= 0) ? xm / 4 : -((3 - xm) / 4);
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int e_addr(input int x, input int y, input int k);
    int ry, wx;
    ry = clampi(y - 2 + k / 3, 0, H - 1);
    wx = clampi(base_col(x) + k % 3, 0, W - 1);
    return ry * W + wx;
  endfunction

  function automatic logic [31:0] e_data(input int x, input int y, input int k);
    int wx;
    logic [31:0] w;
    wx = base_col(x) + k % 3;
    w  = mem[e_addr(x, y, k)];
    if (wx < 0)      return {4{w[7:0]}};
    else if (wx > W - 1) return {4{w[31:24]}};
    else             return w;
  endfunction

  // Entered at cycle 0 (just after an edge); returns in cycle 29 with the
  // DUT idle, so a following call issues its start in cycle 29.
  // With 'extra' set, ignored starts are thrown at cycles 5 and 28.
  task automatic run_txn(input int x, input int y, input bit extra);
    int xo;
    xo = (x - 2) & 3;
    $display("txn x0=%0d y0=%0d extra=%0d", x, y, extra);
    x0 = 10'(x);
    y0 = 10'(y);
    start = 1'b1;
    for (int k = 1; k <= 29; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (extra && (k == 5 || k == 28)) begin
        start = 1'b1;
        x0 = 10'(x + 41);
        y0 = 10'(y + 30);
      end
      if (k <= 27) begin
        chk("rd", rd, 1);
        chk("addr", addr, e_addr(x, y, k - 1));
      end else begin
        chk("rd_off", rd, 0);
      end
      chk("busy", busy, (k <= 28) ? 1 : 0);
      chk("done", done, (k == 28) ? 1 : 0);
      chk("win_valid", win_valid, (k >= 2 && k <= 28) ? 1 : 0);
      if (k >= 2 && k <= 28) begin
        chk("win_data", win_data, e_data(x, y, k - 2));
        chk("win_row", win_row, (k - 2) / 3);
        chk("win_col", win_col, (k - 2) % 3);
      end
      if (k == 1 || k == 29) chk("win_xoff", win_xoff, xo);
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < W * H; i++) mem[i] = $urandom;

    // Reset state.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_rd", rd, 0);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", win_valid, 0);
    chk("rst_data", win_data, 0);
    chk("rst_row", win_row, 0);
    chk("rst_col", win_col, 0);
    chk("rst_xoff", win_xoff, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Interior block, then both overhang corners.
    run_txn(16, 16, 0);
    chk("scn1_first_addr", e_addr(16, 16, 0) == 619 ? 1 : 0, 1);
    run_txn(-5, -10, 0);
    run_txn(174, 140, 0);

    // Starts at 0, 5, 28 and 29: the cycle-29 request runs, first rd at 30.
    run_txn(16, 16, 1);
    run_txn(100, 60, 0);
    @(posedge clk); #1;

    // Reset in cycle 10 for two cycles aborts the transaction.
    $display("txn abort x0=16 y0=16 reset at cycle 10");
    x0 = 10'(16);
    y0 = 10'(16);
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_rd", rd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", win_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_addr", addr, 0);
    @(posedge clk); #1;
    chk("abort_busy2", busy, 0);
    chk("abort_done2", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_done3", done, 0);
    @(posedge clk); #1;
    chk("abort_idle", busy, 0);
    run_txn(16, 16, 0);

    // Random block positions, including off-picture ones.
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      run_txn(int'($urandom_range(240)) - 40, int'($urandom_range(200)) - 30, 0);
    end

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
